// File: rtl/aes_pkg.sv
// Shared AES-256 key schedule definitions.
//   AES256_NK          : number of 32-bit words in the cipher key
//   AES256_SCHED_WORDS : number of schedule words w[0..59] (15 round keys)
//   kx_state_t         : key expander FSM state encoding
//   aes_rcon()         : round constant byte Rcon[1..7] (index 0 is unused)
package aes_pkg;

    localparam int AES256_NK          = 8;
    localparam int AES256_SCHED_WORDS = 60;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } kx_state_t;

    // AES-256 only consumes Rcon[1..7]; i/8 never exceeds 7 for i <= 59.
    function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational (same table as the round stages).
//   value  : input byte
//   result : SubBytes(value)
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign result = SBOX[value];

endmodule

// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule generator. Accepts the 8-word cipher key on a
// valid/ready stream and writes all 60 schedule words, one per clock, into the
// key BRAM consumed by the aes256 core.
//   clkIn       : clock
//   resetIn     : synchronous active-high reset
//   startIn     : begin a new expansion (honoured in IDLE or DONE)
//   keyWordIn   : cipher key word, w[0] first
//   keyValidIn  : keyWordIn valid
//   keyReadyOut : key word accepted this cycle when valid (LOAD only)
//   keyAddrOut  : BRAM word address (BASE_ADDR + i)
//   keyDataOut  : BRAM write data (w[i])
//   keyWeOut    : BRAM byte enables, 4'b1111 on a write cycle
//   busyOut     : high in LOAD and EXPAND
//   doneOut     : high once the schedule is complete, until the next start
//
// state  | meaning
// IDLE   | after reset, waiting for startIn
// LOAD   | accepting key words w[0..7], each written straight to the BRAM
// EXPAND | generating w[8..59], one word per clock, no stalls
// DONE   | schedule complete; startIn re-enters LOAD and overwrites it
module aes256_key_expander
    import aes_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic              startIn,
    input  logic [31:0]       keyWordIn,
    input  logic              keyValidIn,
    output logic              keyReadyOut,
    output logic [ADDR_W-1:0] keyAddrOut,
    output logic [31:0]       keyDataOut,
    output logic [3:0]        keyWeOut,
    output logic              busyOut,
    output logic              doneOut
);

    localparam logic [ADDR_W-1:0] BASE         = ADDR_W'(BASE_ADDR);
    localparam logic [5:0]        LAST_KEY_IDX = 6'(AES256_NK - 1);
    localparam logic [5:0]        LAST_IDX     = 6'(AES256_SCHED_WORDS - 1);

    kx_state_t    state;
    logic [5:0]   idx;
    // Sliding window of the last eight words: [31:0] = w[i-1], [255:224] = w[i-8].
    logic [255:0] window;

    logic [31:0] prev_word;
    logic [31:0] oldest_word;
    logic [31:0] rot_word;
    logic [31:0] sub_in;
    logic [31:0] sub_word;
    logic [31:0] temp_word;
    logic [31:0] next_word;

    assign prev_word   = window[31:0];
    assign oldest_word = window[255:224];
    assign rot_word    = {prev_word[23:0], prev_word[31:24]};
    // A single SubWord serves both i%8==0 (rotated) and i%8==4 (unrotated).
    assign sub_in      = (idx[2:0] == 3'd0) ? rot_word : prev_word;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .value  (sub_in[8*g +: 8]),
            .result (sub_word[8*g +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        if (idx[2:0] == 3'd0) begin
            temp_word = sub_word ^ {aes_rcon(idx[5:3]), 24'h000000};
        end else if (idx[2:0] == 3'd4) begin
            temp_word = sub_word;
        end
    end

    assign next_word = oldest_word ^ temp_word;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state       <= IDLE;
            keyReadyOut <= 1'b0;
            keyAddrOut  <= BASE;
            keyDataOut  <= '0;
            keyWeOut    <= 4'h0;
            busyOut     <= 1'b0;
            doneOut     <= 1'b0;
            idx         <= '0;
            window      <= '0;
        end else begin
            keyWeOut <= 4'h0;
            case (state)
                IDLE, DONE: begin
                    if (startIn) begin
                        state       <= LOAD;
                        keyReadyOut <= 1'b1;
                        busyOut     <= 1'b1;
                        doneOut     <= 1'b0;
                        idx         <= '0;
                        window      <= '0;
                    end else if (state == DONE) begin
                        doneOut <= 1'b1;
                    end
                end
                LOAD: begin
                    if (keyValidIn && keyReadyOut) begin
                        keyDataOut <= keyWordIn;
                        keyAddrOut <= BASE + ADDR_W'(idx);
                        keyWeOut   <= 4'hF;
                        window     <= {window[223:0], keyWordIn};
                        idx        <= idx + 6'd1;
                        if (idx == LAST_KEY_IDX) begin
                            state       <= EXPAND;
                            keyReadyOut <= 1'b0;
                        end
                    end
                end
                EXPAND: begin
                    keyDataOut <= next_word;
                    keyAddrOut <= BASE + ADDR_W'(idx);
                    keyWeOut   <= 4'hF;
                    window     <= {window[223:0], next_word};
                    idx        <= idx + 6'd1;
                    // doneOut follows one edge later, from the DONE state itself.
                    if (idx == LAST_IDX) begin
                        state   <= DONE;
                        busyOut <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    keyReadyOut <= 1'b0;
                    busyOut     <= 1'b0;
                    doneOut     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Self-checking bench for aes256_key_expander. Two instances: BASE_ADDR=0 and
// BASE_ADDR=64. Expected BRAM writes come from an independent key schedule
// model (S-box derived from GF(2^8) inversion) and are queued per instance.
module tb_aes256_key_expander;
    import aes_pkg::*;

    typedef logic [7:0][31:0]  key_t;
    typedef logic [59:0][31:0] sched_t;
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, start0, valid0, rst1, start1, valid1;
    logic [31:0] word0, word1;
    logic        ready0, busy0, done0, ready1, busy1, done1;
    logic [7:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic [3:0]  we0, we1;

    aes256_key_expander #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clkIn(clk), .resetIn(rst0), .startIn(start0), .keyWordIn(word0),
        .keyValidIn(valid0), .keyReadyOut(ready0), .keyAddrOut(addr0),
        .keyDataOut(data0), .keyWeOut(we0), .busyOut(busy0), .doneOut(done0)
    );

    aes256_key_expander #(.ADDR_W(8), .BASE_ADDR(64)) dut1 (
        .clkIn(clk), .resetIn(rst1), .startIn(start1), .keyWordIn(word1),
        .keyValidIn(valid1), .keyReadyOut(ready1), .keyAddrOut(addr1),
        .keyDataOut(data1), .keyWeOut(we1), .busyOut(busy1), .doneOut(done1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         exp_q0[$];
    wr_t         exp_q1[$];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    int          wcount0 = 0;
    int          wcount1 = 0;

    // ---------------- write monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (we0 !== 4'h0) begin
            n_checks++;
            if (exp_q0.size() == 0) begin
                $display("FAIL wr0_unexpected addr=%0d data=%h we=%b", addr0, data0, we0);
            end else begin
                wr_t e;
                e = exp_q0.pop_front();
                if (addr0 !== e.addr || data0 !== e.data || we0 !== 4'hF)
                    $display("FAIL wr0 got addr=%0d data=%h we=%b, want addr=%0d data=%h we=1111",
                             addr0, data0, we0, e.addr, e.data);
                else n_pass++;
            end
            mem0[addr0] = data0;
            wcount0++;
        end
    end

    always @(negedge clk) begin
        if (we1 !== 4'h0) begin
            n_checks++;
            if (exp_q1.size() == 0) begin
                $display("FAIL wr1_unexpected addr=%0d data=%h we=%b", addr1, data1, we1);
            end else begin
                wr_t e;
                e = exp_q1.pop_front();
                if (addr1 !== e.addr || data1 !== e.data || we1 !== 4'hF)
                    $display("FAIL wr1 got addr=%0d data=%h we=%b, want addr=%0d data=%h we=1111",
                             addr1, data1, we1, e.addr, e.data);
                else n_pass++;
            end
            mem1[addr1] = data1;
            wcount1++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int k = 0; k < 254; k++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] v);
        return {sbox_ref(v[31:24]), sbox_ref(v[23:16]), sbox_ref(v[15:8]), sbox_ref(v[7:0])};
    endfunction

    function automatic sched_t expand_ref(input key_t k);
        sched_t     w;
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[i];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword_ref({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subword_ref(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return w;
    endfunction

    function automatic key_t mk_key(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        key_t k;
        k[0] = a0; k[1] = a1; k[2] = a2; k[3] = a3;
        k[4] = a4; k[5] = a5; k[6] = a6; k[7] = a7;
        return k;
    endfunction

    // ---------------- signal access helpers ----------------
    task automatic set_in(input bit sel, input logic s, input logic v, input logic [31:0] w);
        if (sel) begin start1 = s; valid1 = v; word1 = w; end
        else     begin start0 = s; valid0 = v; word0 = w; end
    endtask

    function automatic logic rdy(input bit sel); return sel ? ready1 : ready0; endfunction
    function automatic logic dn(input bit sel);  return sel ? done1  : done0;  endfunction
    function automatic logic bsy(input bit sel); return sel ? busy1  : busy0;  endfunction
    function automatic logic [3:0] wen(input bit sel); return sel ? we1 : we0; endfunction

    // Queue the expected schedule, start, and feed the key with random gaps.
    // e8 is the edge number on which the 8th word is accepted.
    task automatic load_key(input bit sel, input key_t k, input int max_gap, output int e8);
        sched_t     w;
        logic [7:0] base;
        int         n, guard, gap;
        bit         acc_now, acc_last;
        w    = expand_ref(k);
        base = sel ? 8'd64 : 8'd0;
        e8   = -1000;
        for (int i = 0; i < 60; i++) begin
            wr_t e;
            e.addr = base + 8'(i);
            e.data = w[i];
            if (sel) exp_q1.push_back(e); else exp_q0.push_back(e);
        end
        if (sel) wcount1 = 0; else wcount0 = 0;
        @(negedge clk);
        set_in(sel, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, $urandom);
        n_checks++;
        if (rdy(sel) !== 1'b1 || dn(sel) !== 1'b0 || bsy(sel) !== 1'b1)
            $display("FAIL start_edge got ready=%b done=%b busy=%b, want ready=1 done=0 busy=1",
                     rdy(sel), dn(sel), bsy(sel));
        else n_pass++;
        n = 0; guard = 0; gap = 0; acc_last = 0;
        while (n < 8 && guard < 200) begin
            n_checks++;
            if (wen(sel) !== (acc_last ? 4'hF : 4'h0))
                $display("FAIL we_load got we=%b, want %b", wen(sel), acc_last ? 4'hF : 4'h0);
            else n_pass++;
            acc_now = 0;
            if (gap > 0) begin
                set_in(sel, 1'b0, 1'b0, $urandom);
                gap--;
            end else begin
                set_in(sel, 1'b0, 1'b1, k[n]);
                if (rdy(sel) === 1'b1) begin
                    acc_now = 1;
                    if (n == 7) e8 = cyc + 1;
                    n++;
                    gap = $urandom_range(max_gap, 0);
                end
            end
            @(negedge clk);
            acc_last = acc_now;
            guard++;
        end
        set_in(sel, 1'b0, 1'b0, 32'h0);
        if (n < 8) begin
            n_checks++;
            $display("FAIL load_timeout got %0d words accepted, want 8", n);
        end
    endtask

    // Wait for doneOut, optionally pulsing start+valid once at cycle pulse_at.
    task automatic wait_done(input bit sel, input int e8, input int pulse_at);
        int guard = 0;
        while (dn(sel) !== 1'b1 && guard < 100) begin
            if (guard == pulse_at) set_in(sel, 1'b1, 1'b1, 32'hdeadbeef);
            else                   set_in(sel, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            guard++;
        end
        set_in(sel, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (dn(sel) !== 1'b1)
            $display("FAIL done_timeout got done=%b, want 1", dn(sel));
        else if (cyc - e8 != 53)
            $display("FAIL done_latency got %0d edges, want 53", cyc - e8);
        else n_pass++;
    endtask

    task automatic finish_run(input bit sel);
        int left, cnt;
        left = sel ? exp_q1.size() : exp_q0.size();
        cnt  = sel ? wcount1 : wcount0;
        n_checks++;
        if (left != 0 || cnt != 60)
            $display("FAIL run_count got writes=%0d pending=%0d, want writes=60 pending=0", cnt, left);
        else n_pass++;
        n_checks++;
        if (bsy(sel) !== 1'b0 || wen(sel) !== 4'h0 || rdy(sel) !== 1'b0)
            $display("FAIL done_outputs got busy=%b we=%b ready=%b, want 0 0000 0",
                     bsy(sel), wen(sel), rdy(sel));
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    key_t fips_key;

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready0 !== 1'b0 || addr0 !== 8'd0 || data0 !== 32'h0 || we0 !== 4'h0 ||
            busy0 !== 1'b0 || done0 !== 1'b0 || dut0.state !== IDLE)
            $display("FAIL reset0 got ready=%b addr=%0d data=%h we=%b busy=%b done=%b, want 0 0 0 0 0 0",
                     ready0, addr0, data0, we0, busy0, done0);
        else n_pass++;
        n_checks++;
        if (ready1 !== 1'b0 || addr1 !== 8'd64 || data1 !== 32'h0 || we1 !== 4'h0 ||
            busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL reset1 got ready=%b addr=%0d data=%h we=%b busy=%b done=%b, want 0 64 0 0 0 0",
                     ready1, addr1, data1, we1, busy1, done1);
        else n_pass++;
        rst0 = 1'b0; rst1 = 1'b0;
        // valid outside LOAD must be ignored while idle
        valid0 = 1'b1; word0 = 32'h12345678;
        repeat (3) @(negedge clk);
        valid0 = 1'b0;
        n_checks++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0 || we0 !== 4'h0)
            $display("FAIL idle_hold got ready=%b busy=%b we=%b, want 0 0 0", ready0, busy0, we0);
        else n_pass++;
    endtask

    task automatic test_fips();
        int          e8;
        int          chk_addr [9] = '{8, 9, 11, 12, 56, 57, 58, 59, 0};
        logic [31:0] chk_val  [9] = '{32'h9ba35411, 32'h8e6925af, 32'h2067fcde, 32'ha8b09c1a,
                                      32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e,
                                      32'h603deb10};
        load_key(1'b0, fips_key, 0, e8);
        wait_done(1'b0, e8, -1);
        finish_run(1'b0);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (mem0[chk_addr[i]] !== chk_val[i])
                $display("FAIL fips_w%0d got %h, want %h", chk_addr[i], mem0[chk_addr[i]], chk_val[i]);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        int e8;
        load_key(1'b0, fips_key, 3, e8);
        wait_done(1'b0, e8, -1);
        finish_run(1'b0);
    endtask

    task automatic test_zero_key_base64();
        int     e8;
        sched_t w;
        key_t   zk;
        zk = '0;
        w  = expand_ref(zk);
        load_key(1'b1, zk, 1, e8);
        wait_done(1'b1, e8, -1);
        finish_run(1'b1);
        for (int i = 64; i < 72; i++) begin
            n_checks++;
            if (mem1[i] !== 32'h0) $display("FAIL zero_w%0d got %h, want 00000000", i, mem1[i]);
            else n_pass++;
        end
        n_checks++;
        if (mem1[72] !== 32'h62636363) $display("FAIL zero_w72 got %h, want 62636363", mem1[72]);
        else n_pass++;
        n_checks++;
        if (mem1[123] !== w[59]) $display("FAIL zero_w123 got %h, want %h", mem1[123], w[59]);
        else n_pass++;
    endtask

    task automatic test_start_in_expand();
        int e8;
        load_key(1'b0, mk_key(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                              32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f), 0, e8);
        wait_done(1'b0, e8, 10);
        finish_run(1'b0);
    endtask

    task automatic test_reset_mid_expand();
        int   e8, guard;
        key_t k;
        k = mk_key($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        load_key(1'b0, k, 0, e8);
        guard = 0;
        while (!(we0 === 4'hF && addr0 === 8'd29) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rst0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (we0 !== 4'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b0 || dut0.state !== IDLE)
            $display("FAIL reset_mid got we=%b busy=%b done=%b ready=%b, want 0000 0 0 0",
                     we0, busy0, done0, ready0);
        else n_pass++;
        n_checks++;
        if (exp_q0.size() != 30)
            $display("FAIL reset_mid_pending got %0d unwritten, want 30", exp_q0.size());
        else n_pass++;
        exp_q0.delete();
        rst0 = 1'b0;
        load_key(1'b0, k, 2, e8);
        wait_done(1'b0, e8, -1);
        finish_run(1'b0);
    endtask

    task automatic test_back_to_back();
        int e8;
        load_key(1'b0, mk_key(32'hffffffff, 32'h00000000, 32'hdeadbeef, 32'hcafef00d,
                              32'h01234567, 32'h89abcdef, 32'h55aa55aa, 32'h0f0f0f0f), 0, e8);
        wait_done(1'b0, e8, -1);
        finish_run(1'b0);
    endtask

    initial begin
        fips_key = mk_key(32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                          32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4);
        test_reset();
        test_fips();
        test_gaps();
        test_zero_key_base64();
        test_start_in_expand();
        test_reset_mid_expand();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
